decode_ibuf: RTL
================

# decode_ibuf

Parametrised instruction buffer that sits between the fetch stage and the decode stage of the LC-3 pipeline. Each entry holds the IMem_dout word and its PC+1 value. The buffer decouples fetch from decode with a DEPTH-entry FIFO and adds three things to the single-register decode input: flush on redirect, overflow detection and occupancy reporting. Decode consumes the head entry through `enable_decode`.

## Interface
- `DATA_W`, 16, instruction word width
- `PC_W`, 16, NPC width
- `DEPTH`, 4, entry count; power of two, at least 2
- `clock` in 1: the single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low.
- `push` in 1: fetch presents a valid entry.
- `dout` in DATA_W: instruction word (IMem_dout).
- `npc_in` in PC_W: PC+1 for `dout`.
- `enable_decode` in 1: decode pops the head entry.
- `flush` in 1: branch/redirect; discard all entries.
- `full` out 1: count == DEPTH.
- `valid_out` out 1: head entry present.
- `instr_out` out DATA_W: head instruction.
- `npc_out` out PC_W: head NPC.
- `count` out $clog2(DEPTH+1): occupancy.
- `overflow` out 1: sticky; set when a push is dropped.

## Operation
- Storage is a circular array with a write pointer and a read pointer, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus a separate occupancy counter.
- Push is accepted when `push && (!full || enable_decode)`. Pushing into a full buffer is therefore legal in the same cycle as a pop.
- Pop is accepted when `enable_decode && valid_out`. `enable_decode` on an empty buffer is ignored; pointers and count do not change.
- Push while full without a pop: the entry is dropped and `overflow` is set. `overflow` stays set until `reset` or `flush`.
- `flush` has the highest priority:
  - next cycle: pointers = 0, count = 0, `overflow` = 0;
  - a push or pop in the flush cycle is discarded.
- Occupancy update, when there is no flush:
  - count +1 on push only;
  - count −1 on pop only;
  - count unchanged when both occur.
- Outputs are driven combinationally from the head slot.
  - When `valid_out` = 0, `instr_out` and `npc_out` are 0 and never X.
- Reset state: pointers 0, count 0, `full` 0, `valid_out` 0, `instr_out` 0, `npc_out` 0, `overflow` 0. Storage contents need not be cleared.
- A `reset` assertion in the middle of operation clears all of the above immediately, with no clock edge needed.

## Timing
- Push to visible at the head: 1 cycle, with the entry written at the rising edge (non-bypass build).
- Pop: the head advances at the edge where `enable_decode` && `valid_out`. The next entry appears the same cycle after that edge.
- `full`, `count` and `valid_out` are derived from registered state and change only after an edge. The one exception is the bypass path described under Configuration.
- Throughput is one push and one pop per cycle sustained, at any occupancy.

## Configuration
- Macro: `DECODE_IBUF_BYPASS_EN`.
- Defined:
  - When count == 0, `flush` = 0 and `push` = 1, the outputs pass straight through in the same cycle: `valid_out` = 1, `instr_out` = `dout`, `npc_out` = `npc_in`.
  - If `enable_decode` is also 1 that cycle, the entry is consumed and is not written; count stays 0.
  - If `enable_decode` is 0, the entry is written normally.
- Undefined: no combinational path from inputs to outputs. Empty-buffer latency is always 1 cycle.

## Test plan
- Reset then idle: after reset deasserts, hold inputs at 0 for 5 cycles → `count` = 0, `valid_out` = 0, `instr_out` = 0x0000, `overflow` = 0.
- Fill and drain, DEPTH = 4:
  - push 0x1021/0x3001, 0x5262/0x3002, 0x0E03/0x3003, 0x2204/0x3004 → `full` = 1, `count` = 4;
  - then 4 pops → those exact pairs come out in order, then `valid_out` = 0.
- Overflow: with the buffer full, push 0xFFFF without a pop → dropped, `overflow` = 1, `count` = 4. After draining, 0xFFFF never appears.
- Simultaneous push and pop while full: push 0xAAAA with `enable_decode` = 1 → `count` stays 4, `overflow` = 0, 0xAAAA is the 4th entry popped.
- Flush: with 3 entries, assert `flush` together with `push` of 0x1234 → next cycle `count` = 0, `valid_out` = 0; 0x1234 never appears.
- Bypass: on an empty buffer, push 0x6C05/0x3010 with `enable_decode` = 1.
  - With `DECODE_IBUF_BYPASS_EN`: the same cycle shows `valid_out` = 1 and `instr_out` = 0x6C05, then `count` = 0 after the edge.
  - Without it: `valid_out` = 0 that cycle, then `valid_out` = 1 and `instr_out` = 0x6C05 on the next cycle.
  - Also assert `reset` mid-fill in both builds → all outputs are 0 immediately.

Source files
------------

// File: rtl/decode_ibuf_if.sv
// Fetch-to-decode instruction buffer port bundle; master is the fetch/decode side, slave is the buffer.
interface decode_ibuf_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int DEPTH  = 4
);
  logic                         push;
  logic [DATA_W-1:0]            dout;
  logic [PC_W-1:0]              npc_in;
  logic                         enable_decode;
  logic                         flush;
  logic                         full;
  logic                         valid_out;
  logic [DATA_W-1:0]            instr_out;
  logic [PC_W-1:0]              npc_out;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;

  modport master (
    output push, dout, npc_in, enable_decode, flush,
    input  full, valid_out, instr_out, npc_out, count, overflow
  );

  modport slave (
    input  push, dout, npc_in, enable_decode, flush,
    output full, valid_out, instr_out, npc_out, count, overflow
  );
endinterface

// File: rtl/decode_ibuf.sv
// DEPTH-entry fetch->decode FIFO (instr + NPC) with flush, sticky overflow and occupancy; head visible 1 cycle after push.
// A push into a full buffer without a same-cycle pop is dropped; DECODE_IBUF_BYPASS_EN adds an empty-buffer same-cycle bypass.
module decode_ibuf #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int DEPTH  = 4
) (
  input logic          clock,
  input logic          reset,
  decode_ibuf_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]   npc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              full_int;
  logic              head_vld;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              wr_en;

  assign full_int = (cnt == CNT_W'(DEPTH));
  assign head_vld = (cnt != '0);
  assign pop      = bus.enable_decode && head_vld;
  // A full buffer can still take a push when the head leaves in the same cycle.
  assign push_ok  = bus.push && (!full_int || bus.enable_decode);
  assign drop     = bus.push && full_int && !bus.enable_decode;

`ifdef DECODE_IBUF_BYPASS_EN
  logic byp;
  assign byp   = bus.push && !bus.flush && !head_vld;
  // Bypassed entry consumed by decode this cycle never lands in storage.
  assign wr_en = push_ok && !(byp && bus.enable_decode);
`else
  assign wr_en = push_ok;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !bus.flush) begin
      instr_mem[wr_ptr] <= bus.dout;
      npc_mem[wr_ptr]   <= bus.npc_in;
    end
  end

  // Head outputs are forced to zero when empty so stale storage never leaks out.
  always_comb begin
    bus.valid_out = head_vld;
    bus.instr_out = '0;
    bus.npc_out   = '0;
    if (head_vld) begin
      bus.instr_out = instr_mem[rd_ptr];
      bus.npc_out   = npc_mem[rd_ptr];
    end
`ifdef DECODE_IBUF_BYPASS_EN
    else if (byp) begin
      bus.valid_out = 1'b1;
      bus.instr_out = bus.dout;
      bus.npc_out   = bus.npc_in;
    end
`endif
  end

  assign bus.full     = full_int;
  assign bus.count    = cnt;
  assign bus.overflow = ovf;
endmodule
